mul_nbit: RTL and testbench

MUL_NBIT -- requirements
Module: mul_nbit

---
 rtl/mul_nbit.sv | 91 +++++++++
 tb/tb_mul_nbit.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mul_nbit.sv
// ----------------------------------------------------------------------------
// mul_nbit -- sequential shift-add unsigned multiplier
//
// Free-running engine: one LOAD cycle samples the operands, then n RUN cycles
// each retire one multiplier bit. The finished product is published on the
// last RUN cycle and held until the next completion, so the result refreshes
// every n+1 cycles. Only the registered product is visible; the partial
// accumulator never reaches the output.
//
// Parameters
//   n : operand width in bits
//   m : iteration-counter width, 2^m >= n
//
// Ports
//   Clock   in   1    sole clock, rising-edge
//   rst     in   1    synchronous active-low reset
//   product out  2n   registered product {high word, low word}
//   src0    in   n    unsigned multiplicand (sampled at LOAD)
//   src1    in   n    unsigned multiplier   (sampled at LOAD)
// ----------------------------------------------------------------------------
module mul_nbit #(
    parameter int n = 32,
    parameter int m = 5
) (
    input  logic             Clock,
    input  logic             rst,
    output logic [2*n-1:0]   product,
    input  logic [n-1:0]     src0,
    input  logic [n-1:0]     src1
);

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } phase_t;

    // Counter value on the final RUN iteration.
    localparam logic [m-1:0] LAST_COUNT = m'(n - 1);

    phase_t           r_phase;
    logic [n-1:0]     r_mcand;
    logic [n-1:0]     r_mplier;
    logic [2*n-1:0]   r_acc;
    logic [m-1:0]     r_count;
    logic [2*n-1:0]   r_product;

    logic [2*n-1:0]   w_mcand_ext;
    logic [2*n-1:0]   w_addend;
    logic [2*n-1:0]   w_acc_sum;

    // The multiplicand stays put; instead it is weighted by the iteration
    // number, which equals the bit position of the multiplier bit now at the
    // LSB. Everything is 2n wide, so the sum cannot overflow.
    assign w_mcand_ext = {{n{1'b0}}, r_mcand};
    assign w_addend    = r_mplier[0] ? (w_mcand_ext << r_count) : '0;
    assign w_acc_sum   = r_acc + w_addend;

    always_ff @(posedge Clock) begin
        if (!rst) begin
            r_phase   <= LOAD;
            r_acc     <= '0;
            r_count   <= '0;
            r_product <= '0;
        end else begin
            case (r_phase)
                LOAD: begin
                    r_mcand  <= src0;
                    r_mplier <= src1;
                    r_acc    <= '0;
                    r_count  <= '0;
                    r_phase  <= RUN;
                end
                RUN: begin
                    r_acc    <= w_acc_sum;
                    r_mplier <= r_mplier >> 1;
                    r_count  <= r_count + m'(1);
                    // Publish the sum including this cycle's partial product,
                    // not the stale accumulator.
                    if (r_count == LAST_COUNT) begin
                        r_product <= w_acc_sum;
                        r_phase   <= LOAD;
                    end
                end
                default: r_phase <= LOAD;
            endcase
        end
    end

    assign product = r_product;

endmodule

// File: tb/tb_mul_nbit.sv
// ----------------------------------------------------------------------------
// tb_mul_nbit -- bench for mul_nbit
//
// Two instances: 32-bit (defaults) and 8-bit (m=3). A cycle-count model
// predicts the product from plain multiplication, and a negedge process
// compares both instances against it every cycle. Directed sequences add
// literal expectations that pin timing and values.
// ----------------------------------------------------------------------------
module tb_mul_nbit;

    logic        Clock = 1'b0;
    logic        rst32;
    logic        rst8;
    logic [31:0] a32, b32;
    logic [7:0]  a8, b8;
    logic [63:0] p32;
    logic [15:0] p8;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 Clock = ~Clock;

    mul_nbit #(.n(32), .m(5)) dut32 (
        .Clock   (Clock),
        .rst     (rst32),
        .product (p32),
        .src0    (a32),
        .src1    (b32)
    );

    mul_nbit #(.n(8), .m(3)) dut8 (
        .Clock   (Clock),
        .rst     (rst8),
        .product (p8),
        .src0    (a8),
        .src1    (b8)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // k counts clock edges since reset release (0 = the LOAD edge). Over a
    // period of n+1 edges the operands are taken at phase 0 and the product
    // appears at phase n.
    int          k32 = 0;
    logic        mv32 = 1'b0;
    logic [31:0] ma32, mb32;
    logic [63:0] exp32;

    int          k8 = 0;
    logic        mv8 = 1'b0;
    logic [7:0]  ma8, mb8;
    logic [15:0] exp8;

    always @(posedge Clock) begin
        if (!rst32) begin
            k32   <= 0;
            exp32 <= '0;
            mv32  <= 1'b1;
        end else begin
            if (k32 % 33 == 0) begin
                ma32 <= a32;
                mb32 <= b32;
            end
            if (k32 % 33 == 32) exp32 <= {32'b0, ma32} * {32'b0, mb32};
            k32 <= k32 + 1;
        end
    end

    always @(posedge Clock) begin
        if (!rst8) begin
            k8   <= 0;
            exp8 <= '0;
            mv8  <= 1'b1;
        end else begin
            if (k8 % 9 == 0) begin
                ma8 <= a8;
                mb8 <= b8;
            end
            if (k8 % 9 == 8) exp8 <= {8'b0, ma8} * {8'b0, mb8};
            k8 <= k8 + 1;
        end
    end

    always @(negedge Clock) begin
        if (mv32) check("model32", p32, exp32);
        if (mv8)  check("model8", {48'b0, p8}, {48'b0, exp8});
    end

    // ---------------- directed stimulus ----------------
    task automatic edges(input int k);
        repeat (k) @(posedge Clock);
        @(negedge Clock);
    endtask

    // Reset, load operands, release; returns at the completion edge.
    task automatic run32(input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input string name);
        rst32 = 1'b0;
        a32   = a;
        b32   = b;
        edges(1);
        rst32 = 1'b1;
        edges(33);
        check(name, p32, exp);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst32 = 1'b0;
        rst8  = 1'b0;
        a32 = '0; b32 = '0; a8 = '0; b8 = '0;
        edges(2);
        check("reset32", p32, 64'd0);
        check("reset8", {48'b0, p8}, 64'd0);

        // First result after release, 5*2 at edge 33.
        a32 = 32'd5; b32 = 32'd2; rst32 = 1'b1;
        edges(32);
        check("pre_first", p32, 64'd0);
        edges(1);
        check("first_5x2", p32, 64'd10);

        // Operand change mid-RUN is ignored until the next LOAD.
        edges(5);
        a32 = 32'd7;
        edges(28);
        check("midrun_change_old", p32, 64'd10);
        edges(32);
        check("hold_before_14", p32, 64'd10);
        edges(1);
        check("after_change_14", p32, 64'd14);

        // One-edge reset mid-RUN.
        edges(10);
        rst32 = 1'b0;
        edges(1);
        check("midrun_reset", p32, 64'd0);
        rst32 = 1'b1;
        edges(32);
        check("post_reset_pending", p32, 64'd0);
        edges(1);
        check("post_reset_result", p32, 64'd14);

        // rst pulse entirely between edges has no effect.
        @(posedge Clock);
        #2 rst32 = 1'b0;
        #2 rst32 = 1'b1;
        @(negedge Clock);
        edges(1);
        check("glitch_ignored", p32, 64'd14);
        edges(31);
        check("glitch_next_result", p32, 64'd14);

        // Extreme operands and zero timing.
        run32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "max_x_max");
        a32 = 32'h1234_5678; b32 = 32'd0;
        edges(32);
        check("zero_hold", p32, 64'hFFFF_FFFE_0000_0001);
        edges(1);
        check("zero_result", p32, 64'd0);
        run32(32'd1, 32'h8000_0000, 64'h0000_0000_8000_0000, "one_x_msb");
        run32(32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, "carry_to_high");

        // 8-bit instance: 9-cycle period.
        a8 = 8'hFF; b8 = 8'hFF; rst8 = 1'b1;
        edges(8);
        check("n8_pre", {48'b0, p8}, 64'd0);
        edges(1);
        check("n8_ff_x_ff", {48'b0, p8}, 64'hFE01);
        a8 = 8'd3; b8 = 8'd4;
        edges(8);
        check("n8_hold", {48'b0, p8}, 64'hFE01);
        edges(1);
        check("n8_3x4", {48'b0, p8}, 64'd12);

        // Free-running with operands changing at varied phases; model checks.
        for (int i = 0; i < 12; i++) begin
            a32 = $urandom; b32 = $urandom;
            a8  = 8'($urandom); b8 = 8'($urandom);
            edges(11 + (i % 5));
        end
        edges(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
